// File: rtl/img_pkg.sv
// Shared types and helpers for the windowed frame buffer.
package img_pkg;

  // Buffer life cycle: empty, filling from the pixel stream, serving queries.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  // True when (row, col) addresses a real pixel of a rows x cols frame.
  function automatic logic in_frame(input int row, input int col,
                                    input int rows, input int cols);
    return (row >= 0) && (row < rows) && (col >= 0) && (col < cols);
  endfunction

  // Flat slot of window tap (dr, dc) in a k x k window, upper-left first.
  function automatic int win_idx(input int dr, input int dc, input int k);
    return dr * k + dc;
  endfunction

endpackage

// File: rtl/img_window_mask_gen.sv
// Window geometry: for a centre address, flags which of the K*K taps land
// inside the frame and gives the flat storage index each such tap reads.
module img_window_mask_gen
  import img_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int R     = 1,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS),
  parameter int IDX_W = $clog2(ROWS * COLS),
  parameter int K     = 2 * R + 1,
  parameter int WIN   = K * K
) (
  input  logic [ROW_W-1:0]     row_i,
  input  logic [COL_W-1:0]     col_i,
  output logic                 err_o,
  output logic [WIN-1:0]       inside_o,
  output logic [WIN*IDX_W-1:0] idx_o
);

  logic centre_err;

  // A centre outside the frame suppresses every tap.
  assign centre_err = (int'(row_i) >= ROWS) || (int'(col_i) >= COLS);
  assign err_o      = centre_err;

  for (genvar gi = 0; gi < K; gi++) begin : g_dr
    for (genvar gj = 0; gj < K; gj++) begin : g_dc
      localparam int POS = win_idx(gi, gj, K);

      logic signed [ROW_W:0] r_s;
      logic signed [COL_W:0] c_s;
      logic                  hit;

      // Signed offset so that row 0 minus one is negative, never wrapped.
      always_comb begin
        r_s = $signed({1'b0, row_i}) + $signed((ROW_W + 1)'(gi - R));
        c_s = $signed({1'b0, col_i}) + $signed((COL_W + 1)'(gj - R));
        hit = !centre_err && in_frame(int'(r_s), int'(c_s), ROWS, COLS);
      end

      assign inside_o[POS]               = hit;
      assign idx_o[POS*IDX_W +: IDX_W]   = hit ? IDX_W'(int'(r_s) * COLS + int'(c_s)) : '0;
    end
  end

endmodule

// File: rtl/img_window_buf.sv
// Frame buffer filled by a raster pixel stream, patched by random writes,
// and read through a registered (2R+1)x(2R+1) border-padded window port.
module img_window_buf
  import img_pkg::*;
#(
  parameter int                     ROWS        = 16,
  parameter int                     COLS        = 16,
  parameter int                     PIXEL_WIDTH = 8,
  parameter int                     R           = 1,
  parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE   = '0,
  parameter int                     ROW_W       = $clog2(ROWS),
  parameter int                     COL_W       = $clog2(COLS),
  parameter int                     ADDR_WIDTH  = ROW_W + COL_W
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          start,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  input  logic [PIXEL_WIDTH-1:0]                        pix_data,
  output logic                                          frame_done,
  input  logic                                          wr_en,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr,
  input  logic [PIXEL_WIDTH-1:0]                        wr_data,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [ADDR_WIDTH-1:0]                         req_addr,
  output logic                                          rsp_valid,
  output logic [PIXEL_WIDTH*(2*R+1)*(2*R+1)-1:0]        rsp_window,
  output logic [(2*R+1)*(2*R+1)-1:0]                    rsp_mask,
  output logic                                          rsp_err
);

  localparam int K     = 2 * R + 1;
  localparam int WIN   = K * K;
  localparam int NPIX  = ROWS * COLS;
  localparam int IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  state_e                       state_q;
  logic [IDX_W-1:0]             cnt_q;
  logic                         pix_ready_q;
  logic                         req_ready_q;
  logic                         frame_done_q;

  logic                         rsp_valid_q;
  logic [PIXEL_WIDTH*WIN-1:0]   rsp_window_q, rsp_window_d;
  logic [WIN-1:0]               rsp_mask_q, rsp_mask_d;
  logic                         rsp_err_q, rsp_err_d;

  logic [PIXEL_WIDTH-1:0]       mem_q [NPIX];

  logic                         pix_acc;
  logic                         req_acc;
  logic [ROW_W-1:0]             wr_row;
  logic [COL_W-1:0]             wr_col;
  logic                         wr_ok;
  logic [IDX_W-1:0]             wr_idx;
  logic [WIN-1:0]               tap_inside;
  logic [WIN*IDX_W-1:0]         tap_idx;
  logic                         centre_err;

  assign pix_acc = pix_valid && pix_ready_q;
  assign req_acc = req_valid && req_ready_q;

  assign wr_row  = wr_addr[ADDR_WIDTH-1 -: ROW_W];
  assign wr_col  = wr_addr[COL_W-1:0];
  assign wr_ok   = in_frame(int'(wr_row), int'(wr_col), ROWS, COLS);
  assign wr_idx  = IDX_W'(int'(wr_row) * COLS + int'(wr_col));

  // Load sequencing: handshake readiness and the done pulse are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pix_ready_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            pix_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (start) begin
            cnt_q <= '0;
          end else if (pix_acc) begin
            if (cnt_q == LAST_IDX) begin
              state_q      <= READY;
              cnt_q        <= '0;
              pix_ready_q  <= 1'b0;
              req_ready_q  <= 1'b1;
              frame_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        READY: begin
          if (start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            pix_ready_q <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          pix_ready_q <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: stream fill during LOAD, in-frame patch writes during READY.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && pix_acc && !start) begin
      mem_q[cnt_q] <= pix_data;
    end else if (state_q == READY && wr_en && wr_ok) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  img_window_mask_gen #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .R     (R),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .IDX_W (IDX_W),
    .K     (K),
    .WIN   (WIN)
  ) u_mask_gen (
    .row_i    (req_addr[ADDR_WIDTH-1 -: ROW_W]),
    .col_i    (req_addr[COL_W-1:0]),
    .err_o    (centre_err),
    .inside_o (tap_inside),
    .idx_o    (tap_idx)
  );

  for (genvar gi = 0; gi < WIN; gi++) begin : g_tap
    assign rsp_window_d[gi*PIXEL_WIDTH +: PIXEL_WIDTH] =
      tap_inside[gi] ? mem_q[tap_idx[gi*IDX_W +: IDX_W]] : PAD_VALUE;
  end

  assign rsp_mask_d = tap_inside;
  assign rsp_err_d  = centre_err;

  // Response register: captures the pre-write window for every accepted query.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_window_q <= '0;
      rsp_mask_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= req_acc;
      if (req_acc) begin
        rsp_window_q <= rsp_window_d;
        rsp_mask_q   <= rsp_mask_d;
        rsp_err_q    <= rsp_err_d;
      end
    end
  end

  assign pix_ready  = pix_ready_q;
  assign req_ready  = req_ready_q;
  assign frame_done = frame_done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_window = rsp_window_q;
  assign rsp_mask   = rsp_mask_q;
  assign rsp_err    = rsp_err_q;

endmodule
